// File: rtl/operand_loader_pkg.sv
// Shared settings for the operand loader front-end: operand sizes, framing
// defaults and the loader state encoding.
package operand_loader_pkg;

  localparam int BYTE_W  = 8;
  localparam int SIZE_A  = 8;
  localparam int SIZE_B  = 8;
  localparam int SIZE_C  = 16;
  localparam int C_BYTES = SIZE_C / BYTE_W;

  localparam logic [BYTE_W-1:0] DEFAULT_HEADER  = 8'hA5;
  localparam int                DEFAULT_TIMEOUT = 64;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    GET_A  = 3'd1,
    GET_B  = 3'd2,
    GET_C0 = 3'd3,
    GET_C1 = 3'd4,
    OUT    = 3'd5
  } loader_state_t;

endpackage

// File: rtl/operand_loader_byte_timeout_counter.sv
// Inter-byte idle counter for serial front-ends; expire flags the last
// idle cycle allowed before the owner must abort.
module byte_timeout_counter #(
  parameter int TIMEOUT = 64
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] count_r;

  // idle counter; saturates at LAST until the owner clears it
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_r <= '0;
    end else if (clear) begin
      count_r <= '0;
    end else if (enable && (count_r != LAST)) begin
      count_r <= count_r + CNT_W'(1);
    end else begin
      count_r <= count_r;
    end
  end

  assign expire = (count_r == LAST);

endmodule

// File: rtl/operand_loader.sv
// Serial byte stream to parallel {A, B, C} frame loader with header detect,
// inter-byte timeout and a valid/ready output handshake.
module operand_loader
  import operand_loader_pkg::*;
#(
  parameter logic [BYTE_W-1:0] HEADER      = DEFAULT_HEADER,
  parameter int                TIMEOUT     = DEFAULT_TIMEOUT,
  parameter int                FRAME_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [BYTE_W-1:0]      in_data,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic [SIZE_A-1:0]      out_a,
  output logic [SIZE_B-1:0]      out_b,
  output logic [SIZE_C-1:0]      out_c,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   err_timeout,
  output logic [FRAME_CNT_W-1:0] frame_cnt
);

  loader_state_t state_r, state_next_s;

  logic                   in_ready_r, out_valid_r, err_timeout_r;
  logic [SIZE_A-1:0]      a_hold_r, out_a_r;
  logic [SIZE_B-1:0]      b_hold_r, out_b_r;
  logic [BYTE_W-1:0]      c_lo_hold_r;
  logic [SIZE_C-1:0]      out_c_r;
  logic [FRAME_CNT_W-1:0] frame_cnt_r;

  logic accept_s, active_s, expire_s, timeout_s, handshake_s;

  assign accept_s    = in_valid && in_ready_r;
  assign handshake_s = out_valid_r && out_ready;
  assign active_s    = (state_r == GET_A) || (state_r == GET_B) ||
                       (state_r == GET_C0) || (state_r == GET_C1);
  // an accepted byte in the expiry cycle takes priority over the abort
  assign timeout_s   = active_s && expire_s && !accept_s;

  byte_timeout_counter #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (accept_s || !active_s),
    .enable  (active_s),
    .expire  (expire_s)
  );

  // state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // next-state decode
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s && (in_data == HEADER)) state_next_s = GET_A;
        else                                 state_next_s = IDLE;
      end
      GET_A: begin
        if (accept_s)       state_next_s = GET_B;
        else if (timeout_s) state_next_s = IDLE;
        else                state_next_s = GET_A;
      end
      GET_B: begin
        if (accept_s)       state_next_s = GET_C0;
        else if (timeout_s) state_next_s = IDLE;
        else                state_next_s = GET_B;
      end
      GET_C0: begin
        if (accept_s)       state_next_s = GET_C1;
        else if (timeout_s) state_next_s = IDLE;
        else                state_next_s = GET_C0;
      end
      GET_C1: begin
        if (accept_s)       state_next_s = OUT;
        else if (timeout_s) state_next_s = IDLE;
        else                state_next_s = GET_C1;
      end
      OUT: begin
        if (handshake_s) state_next_s = IDLE;
        else             state_next_s = OUT;
      end
      default: state_next_s = IDLE;
    endcase
  end

  // assembly registers keep a partial frame away from the outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      a_hold_r    <= '0;
      b_hold_r    <= '0;
      c_lo_hold_r <= '0;
    end else begin
      if (accept_s && (state_r == GET_A))  a_hold_r    <= in_data;
      if (accept_s && (state_r == GET_B))  b_hold_r    <= in_data;
      if (accept_s && (state_r == GET_C0)) c_lo_hold_r <= in_data;
    end
  end

  // output frame, handshake flags and delivered-frame counter
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_a_r       <= '0;
      out_b_r       <= '0;
      out_c_r       <= '0;
      out_valid_r   <= 1'b0;
      in_ready_r    <= 1'b0;
      err_timeout_r <= 1'b0;
      frame_cnt_r   <= '0;
    end else begin
      if (accept_s && (state_r == GET_C1)) begin
        out_a_r <= a_hold_r;
        out_b_r <= b_hold_r;
        out_c_r <= {in_data, c_lo_hold_r};
      end
      out_valid_r   <= (state_next_s == OUT);
      in_ready_r    <= (state_next_s != OUT);
      err_timeout_r <= timeout_s;
      if (handshake_s) frame_cnt_r <= frame_cnt_r + FRAME_CNT_W'(1);
    end
  end

  assign in_ready    = in_ready_r;
  assign out_valid   = out_valid_r;
  assign out_a       = out_a_r;
  assign out_b       = out_b_r;
  assign out_c       = out_c_r;
  assign err_timeout = err_timeout_r;
  assign frame_cnt   = frame_cnt_r;

endmodule

// File: tb/tb_operand_loader.sv
// Directed self-checking bench for operand_loader (TIMEOUT=8, 4-bit frame counter).
module tb_operand_loader;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  out_a;
  logic [7:0]  out_b;
  logic [15:0] out_c;
  logic        out_valid;
  logic        out_ready;
  logic        err_timeout;
  logic [3:0]  frame_cnt;

  int errors = 0;
  int checks = 0;
  int err_pulses = 0;

  operand_loader #(
    .HEADER      (8'hA5),
    .TIMEOUT     (8),
    .FRAME_CNT_W (4)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .in_data     (in_data),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .out_a       (out_a),
    .out_b       (out_b),
    .out_c       (out_c),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .err_timeout (err_timeout),
    .frame_cnt   (frame_cnt)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (err_timeout === 1'b1) err_pulses++;

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    in_valid = 1'b1;
    in_data  = b;
    step();
    in_valid = 1'b0;
  endtask

  initial begin
    int pulses0;
    reset_n   = 1'b0;
    in_valid  = 1'b0;
    in_data   = 8'h00;
    out_ready = 1'b0;
    #2;
    check("rst_in_ready", 32'(in_ready), 32'h0);
    check("rst_out_valid", 32'(out_valid), 32'h0);
    check("rst_out_a", 32'(out_a), 32'h0);
    check("rst_out_c", 32'(out_c), 32'h0);
    check("rst_err", 32'(err_timeout), 32'h0);
    check("rst_cnt", 32'(frame_cnt), 32'h0);
    step();
    step();
    reset_n = 1'b1;
    step();
    check("rel_in_ready", 32'(in_ready), 32'h1);

    // basic frame
    out_ready = 1'b1;
    send(8'hA5); send(8'h03); send(8'h04); send(8'h10);
    check("basic_not_yet", 32'(out_valid), 32'h0);
    send(8'h00);
    check("basic_valid", 32'(out_valid), 32'h1);
    check("basic_a", 32'(out_a), 32'h03);
    check("basic_b", 32'(out_b), 32'h04);
    check("basic_c", 32'(out_c), 32'h0010);
    check("basic_in_ready", 32'(in_ready), 32'h0);
    step();
    check("basic_cnt", 32'(frame_cnt), 32'h1);
    check("basic_valid_low", 32'(out_valid), 32'h0);
    check("basic_keep_a", 32'(out_a), 32'h03);

    // backpressure
    out_ready = 1'b0;
    send(8'hA5); send(8'h11); send(8'h22); send(8'h33); send(8'h44);
    in_valid = 1'b1;
    in_data  = 8'hA5;
    for (int i = 0; i < 10; i++) begin
      check("bp_valid", 32'(out_valid), 32'h1);
      check("bp_in_ready", 32'(in_ready), 32'h0);
      check("bp_a", 32'(out_a), 32'h11);
      check("bp_b", 32'(out_b), 32'h22);
      check("bp_c", 32'(out_c), 32'h4433);
      check("bp_cnt", 32'(frame_cnt), 32'h1);
      step();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    step();
    check("bp_after_valid", 32'(out_valid), 32'h0);
    check("bp_after_ready", 32'(in_ready), 32'h1);
    check("bp_after_cnt", 32'(frame_cnt), 32'h2);
    step();
    check("bp_single_hs", 32'(frame_cnt), 32'h2);

    // header filtering
    pulses0 = err_pulses;
    send(8'h00); send(8'hFF);
    check("hf_idle_valid", 32'(out_valid), 32'h0);
    send(8'hA5); send(8'h01); send(8'h02); send(8'h34); send(8'h12);
    check("hf_valid", 32'(out_valid), 32'h1);
    check("hf_a", 32'(out_a), 32'h01);
    check("hf_b", 32'(out_b), 32'h02);
    check("hf_c", 32'(out_c), 32'h1234);
    step();
    check("hf_cnt", 32'(frame_cnt), 32'h3);
    check("hf_no_err", 32'(err_pulses - pulses0), 32'h0);

    // timeout: pulse 8 cycles after the last accepted byte
    send(8'hA5); send(8'h07);
    for (int i = 1; i < 8; i++) begin
      step();
      check("to_quiet", 32'(err_timeout), 32'h0);
    end
    step();
    check("to_pulse", 32'(err_timeout), 32'h1);
    step();
    check("to_pulse_end", 32'(err_timeout), 32'h0);
    check("to_cnt", 32'(frame_cnt), 32'h3);
    check("to_valid", 32'(out_valid), 32'h0);
    check("to_keep_c", 32'(out_c), 32'h1234);
    send(8'hA5); send(8'h01); send(8'h01); send(8'h01); send(8'h00);
    check("to_frame_valid", 32'(out_valid), 32'h1);
    check("to_frame_a", 32'(out_a), 32'h01);
    check("to_frame_c", 32'(out_c), 32'h0001);
    step();
    check("to_frame_cnt", 32'(frame_cnt), 32'h4);

    // byte in the expiry cycle wins
    pulses0 = err_pulses;
    send(8'hA5); send(8'h07);
    for (int i = 1; i < 8; i++) step();
    send(8'h08);
    check("exp_no_err", 32'(err_timeout), 32'h0);
    send(8'h09); send(8'h0A);
    check("exp_valid", 32'(out_valid), 32'h1);
    check("exp_a", 32'(out_a), 32'h07);
    check("exp_b", 32'(out_b), 32'h08);
    check("exp_c", 32'(out_c), 32'h0A09);
    step();
    check("exp_cnt", 32'(frame_cnt), 32'h5);
    check("exp_no_pulse", 32'(err_pulses - pulses0), 32'h0);

    // reset mid-frame
    send(8'hA5); send(8'h09); send(8'h08);
    reset_n = 1'b0;
    #1;
    check("mr_in_ready", 32'(in_ready), 32'h0);
    check("mr_cnt", 32'(frame_cnt), 32'h0);
    check("mr_a", 32'(out_a), 32'h0);
    step();
    reset_n = 1'b1;
    step();
    send(8'h01); send(8'h02); send(8'h03); send(8'h04);
    check("mr_no_frame", 32'(out_valid), 32'h0);
    send(8'hA5); send(8'h01); send(8'h02); send(8'h03); send(8'h04);
    check("mr_valid", 32'(out_valid), 32'h1);
    check("mr_c", 32'(out_c), 32'h0403);
    step();
    check("mr_cnt1", 32'(frame_cnt), 32'h1);

    // counter wrap
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    step();
    for (int i = 1; i <= 17; i++) begin
      send(8'hA5); send(8'(i)); send(8'h00); send(8'h00); send(8'h00);
      check("wrap_a", 32'(out_a), 32'(i & 8'hFF));
      step();
      check("wrap_cnt", 32'(frame_cnt), 32'(i % 16));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
